// File: rtl/beat_key_latch_pkg.sv
// Shared types and constants for the beat-aligned key conditioning stage.
// Holds the debounce FSM encoding, 50 MHz and simulation debounce lengths, and counter helpers.
package beat_key_latch_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;  // 5 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;
  localparam int unsigned CNT_W_DEFAULT           = 18;
  localparam int unsigned CountW                  = 8;

  localparam logic [1:0] EncReleased    = 2'd0;
  localparam logic [1:0] EncPressWait   = 2'd1;
  localparam logic [1:0] EncPressed     = 2'd2;
  localparam logic [1:0] EncReleaseWait = 2'd3;

  typedef enum logic [1:0] {
    StReleased    = EncReleased,
    StPressWait   = EncPressWait,
    StPressed     = EncPressed,
    StReleaseWait = EncReleaseWait
  } deb_state_e;

  function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
    return (v == {CountW{1'b1}}) ? v : v + CountW'(1);
  endfunction

  function automatic logic [CountW-1:0] wrap_inc(input logic [CountW-1:0] v);
    return v + CountW'(1);
  endfunction

endpackage

// File: rtl/beat_key_latch_if.sv
// Bundles the game-side controls and the conditioned key outputs of beat_key_latch.
// The master drives key, beat and control inputs; the slave (the latch) drives the results.
interface beat_key_latch_if;
  import beat_key_latch_pkg::*;

  logic              key_n;
  logic              beat_tick;
  logic              enable;
  logic              clear;
  logic              hit;
  logic              pending;
  logic              key_down;
  logic [CountW-1:0] press_count;
  logic [CountW-1:0] dropped_count;

  modport master (
    output key_n,
    output beat_tick,
    output enable,
    output clear,
    input  hit,
    input  pending,
    input  key_down,
    input  press_count,
    input  dropped_count
  );

  modport slave (
    input  key_n,
    input  beat_tick,
    input  enable,
    input  clear,
    output hit,
    output pending,
    output key_down,
    output press_count,
    output dropped_count
  );

endinterface

// File: rtl/beat_key_latch_key_debouncer.sv
// Two-flop synchroniser plus debounce FSM for an active-low push-button.
// press_evt is a single-cycle strobe on the cycle the FSM commits to PRESSED.
module key_debouncer
  import beat_key_latch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_down,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       key_s;
  deb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       cnt_done;

  // Reset to "released" so a held key after reset still has to be debounced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign key_s    = sync2_q;
  assign cnt_done = (cnt_q == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReleased;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    unique case (state_q)
      StReleased: begin
        if (!key_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (key_s) begin
          state_d = StReleased;
        end else if (cnt_done) begin
          state_d   = StPressed;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPressed: begin
        if (key_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        // A bounce back low returns to PRESSED silently: still the same press.
        if (!key_s) begin
          state_d = StPressed;
        end else if (cnt_done) begin
          state_d = StReleased;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StReleased;
    endcase
  end

  assign key_down = (state_q == StPressed) || (state_q == StReleaseWait);

endmodule

// File: rtl/beat_key_latch.sv
// Turns a debounced press into one beat-aligned hit pulse and keeps press statistics.
// A press waits in `pending` until the next beat_tick; a second press in that window is dropped.
module beat_key_latch
  import beat_key_latch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  beat_key_latch_if.slave  bus
);

  logic              key_down;
  logic              press_evt;
  logic              hit_q, hit_d;
  logic              pending_q, pending_d;
  logic [CountW-1:0] press_cnt_q, press_cnt_d;
  logic [CountW-1:0] drop_cnt_q, drop_cnt_d;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk       (clk),
    .rst       (rst),
    .key_n     (bus.key_n),
    .key_down  (key_down),
    .press_evt (press_evt)
  );

  always_comb begin
    hit_d       = 1'b0;
    pending_d   = pending_q;
    press_cnt_d = press_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (bus.clear) begin
      pending_d   = 1'b0;
      press_cnt_d = '0;
      drop_cnt_d  = '0;
    end else if (!bus.enable) begin
      pending_d = 1'b0;
    end else if (press_evt) begin
      press_cnt_d = wrap_inc(press_cnt_q);
      if (bus.beat_tick) begin
        // Beat consumes either this press or the older pending one; the other stays queued.
        hit_d     = 1'b1;
        pending_d = pending_q;
      end else begin
        if (pending_q) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
        pending_d = 1'b1;
      end
    end else if (bus.beat_tick) begin
      hit_d     = pending_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q       <= 1'b0;
      pending_q   <= 1'b0;
      press_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      hit_q       <= hit_d;
      pending_q   <= pending_d;
      press_cnt_q <= press_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.hit           = hit_q;
  assign bus.pending       = pending_q;
  assign bus.key_down      = key_down;
  assign bus.press_count   = press_cnt_q;
  assign bus.dropped_count = drop_cnt_q;

endmodule

// File: tb/tb_beat_key_latch.sv
// Directed bench for beat_key_latch with DEBOUNCE_CYCLES=4; expected hits go into a
// scoreboard queue that a negedge monitor pops whenever the DUT pulses hit.
module tb_beat_key_latch;
  import beat_key_latch_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  beat_key_latch_if bus ();

  beat_key_latch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
    .CNT_W           (18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int pc;
    int dc;
    int pend;
  } hit_exp_t;

  hit_exp_t exp_q[$];
  hit_exp_t mon_e;
  int       n_checks = 0;
  int       n_errors = 0;
  logic     prev_beat = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every hit must match the oldest expectation and follow a beat_tick cycle.
  always @(negedge clk) begin
    if (!rst && bus.hit === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_hit: got hit=1, expected no hit (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("hit_after_beat", int'(prev_beat), 1);
        check("hit_press_count", int'(bus.press_count), mon_e.pc);
        check("hit_dropped_count", int'(bus.dropped_count), mon_e.dc);
        check("hit_pending", int'(bus.pending), mon_e.pend);
      end
    end
    prev_beat <= bus.beat_tick;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_hit(input int pc, input int dc, input int pend);
    hit_exp_t e;
    e.pc   = pc;
    e.dc   = dc;
    e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic beat_pulse();
    bus.beat_tick = 1'b1;
    tick();
    bus.beat_tick = 1'b0;
    tick(2);
    check("hit_seen", exp_q.size(), 0);
  endtask

  task automatic press(input int hold, input int rel);
    bus.key_n = 1'b0;
    tick(hold);
    bus.key_n = 1'b1;
    tick(rel);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hit"}, int'(bus.hit), 0);
    check({tag, "_pending"}, int'(bus.pending), 0);
    check({tag, "_key_down"}, int'(bus.key_down), 0);
    check({tag, "_press_count"}, int'(bus.press_count), 0);
    check({tag, "_dropped_count"}, int'(bus.dropped_count), 0);
  endtask

  initial begin
    bus.key_n     = 1'b1;
    bus.beat_tick = 1'b0;
    bus.enable    = 1'b0;
    bus.clear     = 1'b0;
    rst           = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst        = 1'b0;
    bus.enable = 1'b1;
    tick(2);

    // Clean press held 20 cycles; press_evt lands 6 edges after the first low sample.
    bus.key_n = 1'b0;
    tick(6);
    check("t1_pending_early", int'(bus.pending), 0);
    tick();
    check("t1_pending", int'(bus.pending), 1);
    check("t1_key_down", int'(bus.key_down), 1);
    check("t1_press_count", int'(bus.press_count), 1);
    tick(13);
    bus.key_n = 1'b1;
    tick(10);
    check("t1_pending_held", int'(bus.pending), 1);
    check("t1_key_up", int'(bus.key_down), 0);
    expect_hit(1, 0, 0);
    beat_pulse();
    check("t1_pending_after", int'(bus.pending), 0);
    check("t1_dropped", int'(bus.dropped_count), 0);

    // Clear, then bounce every 2 cycles: never stable long enough.
    do_clear();
    check("clear_press_count", int'(bus.press_count), 0);
    for (int i = 0; i < 6; i++) begin
      bus.key_n = (i % 2 == 1);
      tick(2);
    end
    bus.key_n = 1'b1;
    tick(10);
    check("t2_pending", int'(bus.pending), 0);
    check("t2_press_count", int'(bus.press_count), 0);
    check("t2_key_down", int'(bus.key_down), 0);

    // Two presses inside one beat window: second is dropped, one hit.
    do_clear();
    press(10, 10);
    check("t3_pending_first", int'(bus.pending), 1);
    press(10, 10);
    check("t3_pending", int'(bus.pending), 1);
    check("t3_press_count", int'(bus.press_count), 2);
    check("t3_dropped", int'(bus.dropped_count), 1);
    expect_hit(2, 1, 0);
    beat_pulse();
    check("t3_pending_after", int'(bus.pending), 0);

    // press_evt coincident with beat_tick while nothing is pending.
    do_clear();
    bus.key_n = 1'b0;
    tick(6);
    bus.beat_tick = 1'b1;
    expect_hit(1, 0, 0);
    tick();
    bus.beat_tick = 1'b0;
    check("t4_pending", int'(bus.pending), 0);
    check("t4_press_count", int'(bus.press_count), 1);
    tick(2);
    check("t4_hit_seen", exp_q.size(), 0);
    tick(5);
    bus.key_n = 1'b1;
    tick(10);

    // enable drops while a press is pending: pending cleared, no hit, counters hold.
    do_clear();
    bus.key_n = 1'b0;
    tick(7);
    check("t5_pending", int'(bus.pending), 1);
    bus.enable = 1'b0;
    tick();
    check("t5_pending_disabled", int'(bus.pending), 0);
    check("t5_press_count", int'(bus.press_count), 1);
    beat_pulse();
    bus.key_n = 1'b1;
    tick(10);
    press(10, 10);
    check("t5_press_ignored", int'(bus.press_count), 1);
    check("t5_pending_ignored", int'(bus.pending), 0);
    bus.enable = 1'b1;
    beat_pulse();
    check("t5_pending_reenabled", int'(bus.pending), 0);

    // Reset mid-debounce with a press pending; held key is accepted once afterwards.
    do_clear();
    press(10, 10);
    check("t6_pending_before", int'(bus.pending), 1);
    bus.key_n = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    check_all_zero("t6_async_reset");
    tick(2);
    rst = 1'b0;
    tick(6);
    check("t6_pending_early", int'(bus.pending), 0);
    tick();
    check("t6_pending", int'(bus.pending), 1);
    check("t6_press_count", int'(bus.press_count), 1);
    check("t6_dropped", int'(bus.dropped_count), 0);
    expect_hit(1, 0, 0);
    beat_pulse();
    bus.key_n = 1'b1;
    tick(10);

    // 256 presses with no beat: press_count wraps to 0, dropped saturates at 255.
    do_clear();
    for (int i = 0; i < 256; i++) press(8, 8);
    check("t7_press_wrap", int'(bus.press_count), 0);
    check("t7_dropped_max", int'(bus.dropped_count), 255);
    check("t7_pending", int'(bus.pending), 1);
    press(8, 8);
    check("t7_press_after_wrap", int'(bus.press_count), 1);
    check("t7_dropped_sat", int'(bus.dropped_count), 255);
    expect_hit(1, 255, 0);
    beat_pulse();

    tick(4);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
